dice_roller: RTL

Parametrised multi-die roller for the dice-game board. A free-running counter cycles through 1..N, where N comes from a runtime die-type select (D4/D6/D8/D10/D12/D20). A roll-button rising edge starts a timed "tumble" animation, then freezes on the final value. The result drives two active-low seven-segment digits (tens, ones), plus a binary value and a done strobe for the scoring logic.

---
 rtl/dice_roller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dice_roller.sv
// Multi-die roller: a free-running 1..N counter is sampled repeatedly during a
// timed tumble after a roll-button rising edge; the final sample is shown on two
// active-low seven-segment digits.
module dice_roller #(
  parameter int TUMBLE_LEN   = 8,
  parameter int TUMBLE_STEP  = 4,
  parameter bit LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll,
  input  logic [2:0] die_sel,
  output logic [6:0] dicenum,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TUMBLE = 2'd1;
  localparam logic [1:0] SHOW   = 2'd2;

  localparam logic [7:0] STEP_LAST = 8'(TUMBLE_STEP - 1);
  localparam logic [7:0] LEN_INIT  = 8'(TUMBLE_LEN);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] sides_of(input logic [2:0] sel);
    logic [6:0] n;
    case (sel)
      3'd0:    n = 7'd4;
      3'd1:    n = 7'd6;
      3'd2:    n = 7'd8;
      3'd3:    n = 7'd10;
      3'd4:    n = 7'd12;
      default: n = 7'd20;
    endcase
    return n;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [1:0] state;
  logic       roll_q;
  logic       roll_edge;
  logic [6:0] cnt;
  logic [6:0] cnt_lim;
  logic [6:0] sides_l;
  logic [7:0] div;
  logic [7:0] updates_left;
  logic [3:0] tens_d;
  logic [3:0] ones_d;

  assign state_dbg = state;
  assign roll_edge = roll & ~roll_q;

  // During a tumble the limit is latched, so die_sel changes cannot bias the roll.
  always_comb begin
    cnt_lim = sides_of(die_sel);
    if (state == TUMBLE) cnt_lim = sides_l;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 7'd1;
    end else if (cnt >= cnt_lim) begin
      cnt <= 7'd1;
    end else begin
      cnt <= cnt + 7'd1;
    end
  end

  // roll_q resets high so a button held through reset needs a release first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      roll_q       <= 1'b1;
      dicenum      <= 7'd0;
      sides_l      <= 7'd20;
      div          <= 8'd0;
      updates_left <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      roll_q <= roll;
      done   <= 1'b0;
      case (state)
        IDLE, SHOW: begin
          if (roll_edge) begin
            state        <= TUMBLE;
            busy         <= 1'b1;
            sides_l      <= sides_of(die_sel);
            div          <= 8'd0;
            updates_left <= LEN_INIT;
          end
        end
        TUMBLE: begin
          if (div == STEP_LAST) begin
            dicenum      <= cnt;
            div          <= 8'd0;
            updates_left <= updates_left - 8'd1;
            if (updates_left == 8'd1) begin
              state <= SHOW;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    tens_d = 4'(dicenum / 7'd10);
    ones_d = 4'(dicenum % 7'd10);
  end

  always_comb begin
    seg_tens = SEG_DASH;
    seg_ones = SEG_DASH;
    if (state != IDLE) begin
      seg_ones = seg_digit(ones_d);
      if (tens_d == 4'd0 && LEADING_ZERO == 1'b0) seg_tens = SEG_BLANK;
      else                                        seg_tens = seg_digit(tens_d);
    end
  end

endmodule
